// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared constants for the two-source round-robin arbiter: state encoding,
// default burst limit and the burst counter width helper.
package mux2_rr_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT0 = 2'd1;
    localparam logic [1:0] ST_GRANT1 = 2'd2;

    localparam int unsigned DEFAULT_MAX_BURST = 4;

    // ceil(log2(max_burst + 1)), never less than one bit
    function automatic int unsigned burst_cnt_width(input int unsigned max_burst);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < (max_burst + 32'd1)) begin
            w = w + 32'd1;
        end
        return (w == 0) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/mux2_dataflow_bus.sv
// Purely combinational 2:1 payload selector driven by the arbiter grant.
module mux2_dataflow_bus #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              sel,
    input  logic [DATA_W-1:0] in0_data,
    input  logic [DATA_W-1:0] in1_data,
    output logic [DATA_W-1:0] data_c
);

    assign data_c = sel ? in1_data : in0_data;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Two-source round-robin arbiter with burst hold; owns the mux select and
// drives a single registered valid/ready output stage.
module mux2_rr_arbiter
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    output logic              in1_ready,
    output logic              sel,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    localparam int unsigned      CNT_W      = burst_cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic              last;
    logic              last_next;
    logic [CNT_W-1:0]  burst_cnt;
    logic [CNT_W-1:0]  burst_cnt_next;

    logic              space_c;
    logic              xfer_c;
    logic              cur_src_c;
    logic              grant_valid_c;
    logic              other_valid_c;
    logic [1:0]        other_state_c;
    logic [DATA_W-1:0] mux_data_c;

    mux2_dataflow_bus #(
        .DATA_W (DATA_W)
    ) u_bus (
        .sel      (sel),
        .in0_data (in0_data),
        .in1_data (in1_data),
        .data_c   (mux_data_c)
    );

    // Readies follow out_ready combinationally so a full register can drain and refill in one edge
    assign space_c   = !out_valid || out_ready;
    assign in0_ready = (state == ST_GRANT0) && space_c;
    assign in1_ready = (state == ST_GRANT1) && space_c;
    assign xfer_c    = (in0_valid && in0_ready) || (in1_valid && in1_ready);

    assign cur_src_c     = (state == ST_GRANT1);
    assign grant_valid_c = cur_src_c ? in1_valid : in0_valid;
    assign other_valid_c = cur_src_c ? in0_valid : in1_valid;
    assign other_state_c = cur_src_c ? ST_GRANT0 : ST_GRANT1;

    always_comb begin
        state_next     = state;
        last_next      = last;
        burst_cnt_next = burst_cnt;
        case (state)
            ST_IDLE: begin
                burst_cnt_next = '0;
                if (in0_valid && in1_valid) begin
                    state_next = last ? ST_GRANT0 : ST_GRANT1;
                end else if (in0_valid) begin
                    state_next = ST_GRANT0;
                end else if (in1_valid) begin
                    state_next = ST_GRANT1;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (!grant_valid_c) begin
                    // Granted source went quiet: hand over or park
                    last_next      = cur_src_c;
                    burst_cnt_next = '0;
                    state_next     = other_valid_c ? other_state_c : ST_IDLE;
                end else if (space_c) begin
                    if (burst_cnt == BURST_LAST) begin
                        burst_cnt_next = '0;
                        if (other_valid_c) begin
                            state_next = other_state_c;
                            last_next  = cur_src_c;
                        end
                    end else begin
                        burst_cnt_next = burst_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next     = ST_IDLE;
                burst_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sel       <= 1'b0;
            last      <= 1'b1;
            burst_cnt <= '0;
        end else begin
            state     <= state_next;
            sel       <= (state_next == ST_GRANT1);
            last      <= last_next;
            burst_cnt <= burst_cnt_next;
        end
    end

    // Output stage: load on transfer, otherwise drain when the sink takes the word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (xfer_c) begin
            out_valid <= 1'b1;
            out_data  <= mux_data_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: directed scenarios plus randomized
// traffic scored against a transaction-level fairness and data model.
module tb_mux2_rr_arbiter;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned BURST  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n = 1'b1;
    logic              in0_valid = 1'b0, in1_valid = 1'b0, out_ready = 1'b0;
    logic [DATA_W-1:0] in0_data = '0, in1_data = '0;
    logic              in0_ready, in1_ready, sel, out_valid;
    logic [DATA_W-1:0] out_data;

    logic              b_rst_n = 1'b1;
    logic              b_in0_valid = 1'b0, b_in1_valid = 1'b0, b_out_ready = 1'b0;
    logic [DATA_W-1:0] b_in0_data = '0, b_in1_data = '0;
    logic              b_in0_ready, b_in1_ready, b_sel, b_out_valid;
    logic [DATA_W-1:0] b_out_data;

    int errors = 0;
    int checks = 0;

    mux2_rr_arbiter #(.DATA_W(DATA_W), .MAX_BURST(BURST)) dut (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
        .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );

    mux2_rr_arbiter #(.DATA_W(DATA_W), .MAX_BURST(1)) dut_b1 (
        .clk(clk), .rst_n(b_rst_n),
        .in0_valid(b_in0_valid), .in0_data(b_in0_data), .in0_ready(b_in0_ready),
        .in1_valid(b_in1_valid), .in1_data(b_in1_data), .in1_ready(b_in1_ready),
        .sel(b_sel), .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
        in0_data = '0; in1_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        b_rst_n = 1'b0;
        #1;
        checks++; if (sel !== 1'b0) begin errors++; $display("FAIL reset_sel: got %0b want 0", sel); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
        checks++; if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
            errors++; $display("FAIL reset_readies: got %0b%0b want 00", in0_ready, in1_ready); end
        checks++; if (b_out_valid !== 1'b0 || b_sel !== 1'b0) begin
            errors++; $display("FAIL reset_b: got valid=%0b sel=%0b want 0 0", b_out_valid, b_sel); end
        tick();
        tick();
        rst_n = 1'b1;
        b_rst_n = 1'b1;
    endtask

    task automatic test_single_source();
        do_reset();
        in0_valid = 1'b1; in0_data = 8'hA0;
        #1;
        checks++; if (in0_ready !== 1'b0) begin errors++; $display("FAIL single_idle_ready: got %0b want 0", in0_ready); end
        tick();
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if (in0_ready !== 1'b1 || sel !== 1'b0) begin
                errors++; $display("FAIL single_ready[%0d]: got ready=%0b sel=%0b want 1 0", i, in0_ready, sel); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== 8'(8'hA0 + i)) begin
                errors++; $display("FAIL single_data[%0d]: got v=%0b d=%0h want 1 %0h", i, out_valid, out_data, 8'(8'hA0 + i)); end
            in0_data = 8'(8'hA0 + i + 1);
        end
        in0_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %0b want 0", out_valid); end
        tick();
    endtask

    task automatic test_round_robin();
        int n0, n1, src;
        logic [DATA_W-1:0] want;
        do_reset();
        n0 = 0; n1 = 0;
        in0_valid = 1'b1; in1_valid = 1'b1; in0_data = 8'h10; in1_data = 8'h80;
        tick();
        for (int k = 0; k < 12; k++) begin
            src = (k / int'(BURST)) % 2;
            #1;
            checks++; if (sel !== 1'(src) || in0_ready !== 1'(src == 0) || in1_ready !== 1'(src == 1)) begin
                errors++; $display("FAIL rr_grant[%0d]: got sel=%0b r=%0b%0b want sel=%0d", k, sel, in0_ready, in1_ready, src); end
            tick();
            want = (src == 0) ? 8'(8'h10 + n0) : 8'(8'h80 + n1);
            checks++; if (out_valid !== 1'b1 || out_data !== want) begin
                errors++; $display("FAIL rr_data[%0d]: got v=%0b d=%0h want 1 %0h", k, out_valid, out_data, want); end
            if (src == 0) begin n0++; in0_data = 8'(8'h10 + n0); end
            else begin n1++; in1_data = 8'(8'h80 + n1); end
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_drop_switch();
        do_reset();
        in0_valid = 1'b1; in1_valid = 1'b1; in0_data = 8'h20; in1_data = 8'h90;
        tick();
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (in0_ready !== 1'b1) begin errors++; $display("FAIL drop_pre_ready[%0d]: got %0b want 1", i, in0_ready); end
            tick();
            checks++; if (out_data !== 8'(8'h20 + i)) begin
                errors++; $display("FAIL drop_pre_data[%0d]: got %0h want %0h", i, out_data, 8'(8'h20 + i)); end
            in0_data = 8'(8'h21 + i);
        end
        in0_valid = 1'b0;
        #1;
        checks++; if (sel !== 1'b0 || in1_ready !== 1'b0) begin
            errors++; $display("FAIL drop_cycle: got sel=%0b r1=%0b want 0 0", sel, in1_ready); end
        tick();
        checks++; if (out_valid !== 1'b0 || sel !== 1'b1) begin
            errors++; $display("FAIL drop_bubble: got v=%0b sel=%0b want 0 1", out_valid, sel); end
        #1;
        checks++; if (in1_ready !== 1'b1 || in0_ready !== 1'b0) begin
            errors++; $display("FAIL drop_grant1: got r=%0b%0b want 01", in0_ready, in1_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h90) begin
            errors++; $display("FAIL drop_first1: got v=%0b d=%0h want 1 90", out_valid, out_data); end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        in0_valid = 1'b1; in0_data = 8'h54;
        tick();
        for (int i = 0; i < 2; i++) begin
            tick();
            in0_data = 8'(8'h55 + i);
        end
        out_ready = 1'b0; in1_valid = 1'b1; in1_data = 8'hC0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
                errors++; $display("FAIL bp_ready[%0d]: got r=%0b%0b want 00", i, in0_ready, in1_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== 8'h55 || sel !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d]: got v=%0b d=%0h sel=%0b want 1 55 0", i, out_valid, out_data, sel); end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (in0_ready !== 1'b1) begin errors++; $display("FAIL bp_resume_ready[%0d]: got %0b want 1", i, in0_ready); end
            tick();
            checks++; if (out_data !== 8'(8'h56 + i)) begin
                errors++; $display("FAIL bp_resume_data[%0d]: got %0h want %0h", i, out_data, 8'(8'h56 + i)); end
            in0_data = 8'(8'h57 + i);
        end
        #1;
        checks++; if (sel !== 1'b1 || in1_ready !== 1'b1 || in0_ready !== 1'b0) begin
            errors++; $display("FAIL bp_rotate: got sel=%0b r=%0b%0b want 1 01", sel, in0_ready, in1_ready); end
        tick();
        checks++; if (out_data !== 8'hC0) begin errors++; $display("FAIL bp_src1_data: got %0h want c0", out_data); end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        in1_valid = 1'b1; in1_data = 8'h30;
        tick();
        for (int i = 0; i < 2; i++) begin
            tick();
            in1_data = 8'(8'h31 + i);
        end
        checks++; if (sel !== 1'b1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL mid_pre: got sel=%0b v=%0b want 1 1", sel, out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || sel !== 1'b0 || in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
            errors++; $display("FAIL mid_async: got v=%0b sel=%0b r=%0b%0b want 0 0 00", out_valid, sel, in0_ready, in1_ready); end
        in0_valid = 1'b1; in0_data = 8'h40;
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (sel !== 1'b0) begin errors++; $display("FAIL mid_tie_sel: got %0b want 0", sel); end
        #1;
        checks++; if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
            errors++; $display("FAIL mid_tie_ready: got r=%0b%0b want 10", in0_ready, in1_ready); end
        tick();
        checks++; if (out_data !== 8'h40) begin errors++; $display("FAIL mid_tie_data: got %0h want 40", out_data); end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_maxburst1();
        logic [DATA_W-1:0] sink_q[$];
        logic [DATA_W-1:0] word;
        int n0, n1, accepted, delivered, exp_src, cyc;
        logic hs0, hs1;
        n0 = 0; n1 = 0; accepted = 0; delivered = 0; exp_src = 0; cyc = 0;
        b_in0_valid = 1'b1; b_in1_valid = 1'b1; b_in0_data = 8'h00; b_in1_data = 8'h80;
        while ((accepted < 20 || delivered < 20) && cyc < 200) begin
            b_out_ready = ((cyc % 2) == 0);
            if (accepted >= 20) begin b_in0_valid = 1'b0; b_in1_valid = 1'b0; end
            #1;
            hs0 = b_in0_valid && b_in0_ready;
            hs1 = b_in1_valid && b_in1_ready;
            if (b_out_valid && b_out_ready) begin
                checks++;
                if (sink_q.size() == 0) begin
                    errors++; $display("FAIL mb1_extra_word: got %0h want none", b_out_data);
                end else begin
                    word = sink_q.pop_front();
                    if (b_out_data !== word) begin errors++; $display("FAIL mb1_sink: got %0h want %0h", b_out_data, word); end
                end
                delivered++;
            end
            if (hs0 || hs1) begin
                checks++; if (hs0 && hs1 || (hs1 ? 1 : 0) != exp_src) begin
                    errors++; $display("FAIL mb1_order[%0d]: got hs=%0b%0b want src %0d", accepted, hs0, hs1, exp_src); end
                word = hs1 ? b_in1_data : b_in0_data;
                sink_q.push_back(word);
                accepted++;
                exp_src = 1 - exp_src;
            end
            tick();
            if (hs0 || hs1) begin
                checks++; if (b_out_valid !== 1'b1 || b_out_data !== word) begin
                    errors++; $display("FAIL mb1_latency: got v=%0b d=%0h want 1 %0h", b_out_valid, b_out_data, word); end
                if (hs1) begin n1++; b_in1_data = 8'(8'h80 + n1); end
                else begin n0++; b_in0_data = 8'(n0); end
            end
            cyc++;
        end
        checks++; if (accepted != 20 || delivered != 20 || sink_q.size() != 0) begin
            errors++; $display("FAIL mb1_complete: got acc=%0d del=%0d left=%0d want 20 20 0", accepted, delivered, sink_q.size()); end
        b_in0_valid = 1'b0; b_in1_valid = 1'b0; b_out_ready = 1'b1;
    endtask

    task automatic test_random();
        logic exp_ov, r0, r1, hs0, hs1, space;
        logic [DATA_W-1:0] last_word;
        int prev_src, run, block_src;
        do_reset();
        exp_ov = 1'b0; last_word = '0; prev_src = -1; run = 0; block_src = -1;
        for (int c = 0; c < 500; c++) begin
            checks++; if (out_valid !== exp_ov || (exp_ov && out_data !== last_word)) begin
                errors++; $display("FAIL rnd_out[%0d]: got v=%0b d=%0h want %0b %0h", c, out_valid, out_data, exp_ov, last_word); end
            if (!in0_valid) begin in0_valid = 1'($urandom_range(0, 1)); in0_data = 8'($urandom); end
            else if ($urandom_range(0, 7) == 0) in0_valid = 1'b0;
            if (!in1_valid) begin in1_valid = 1'($urandom_range(0, 1)); in1_data = 8'($urandom); end
            else if ($urandom_range(0, 7) == 0) in1_valid = 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            r0 = in0_ready; r1 = in1_ready;
            space = !exp_ov || out_ready;
            checks++; if ((r0 && r1) || ((r0 || r1) && !space)) begin
                errors++; $display("FAIL rnd_ready[%0d]: got r=%0b%0b want exclusive and space=%0b", c, r0, r1, space); end
            if (block_src >= 0) begin
                checks++; if ((block_src == 0 ? r0 : r1) !== 1'b0) begin
                    errors++; $display("FAIL rnd_fair[%0d]: got src %0d ready after full burst want 0", c, block_src); end
                block_src = -1;
            end
            hs0 = in0_valid && r0;
            hs1 = in1_valid && r1;
            if (prev_src == 0 && !in0_valid || prev_src == 1 && !in1_valid) run = 0;
            if (hs0 || hs1) begin
                if ((hs1 ? 1 : 0) != prev_src) run = 0;
                prev_src = hs1 ? 1 : 0;
                run++;
                last_word = hs1 ? in1_data : in0_data;
                exp_ov = 1'b1;
                if (run == int'(BURST)) begin
                    if (hs1 ? in0_valid : in1_valid) block_src = prev_src;
                    run = 0;
                end
            end else if (out_ready) begin
                exp_ov = 1'b0;
            end
            tick();
            if (hs0) in0_valid = 1'b0;
            if (hs1) in1_valid = 1'b0;
        end
        idle_inputs();
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_round_robin();
        test_drop_switch();
        test_backpressure();
        test_reset_mid_burst();
        test_maxburst1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
